cache_mem_responder: RTL and testbench

// - Memory-side responder for one cache controller's burst read/write port (rd_*/wr_* groups).
// - Grants fill (read) and write-back (write) bursts, then streams data.
// - Backed by an internal word array of mem_depth entries.
// - Sits between the cache controller and the system memory model; used as RTL backing store and as a DV target.

---
 rtl/cache_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_cache_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side burst responder for one cache controller: grants fill (rd_*) and
// write-back (wr_*) bursts and streams beats to/from an internal word array.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rd_req/rd_addr/rd_len       read burst request (held until rd_gnt)
//   rd_gnt                      one-cycle read grant, addr/len captured here
//   rd_valid/rd_data/rd_ready   read beat handshake
//   rd_done                     one-cycle pulse after the final read beat
//   wr_req/wr_addr/wr_len       write burst request (held until wr_gnt)
//   wr_gnt                      one-cycle write grant, addr/len captured here
//   wr_valid/wr_data/wr_last    write beat from the cache
//   wr_ready                    responder accepts a write beat
//   wr_done                     one-cycle pulse after the final write beat
//
// Build option: define MEM_RSP_STALL_EN to insert one idle cycle after every
// accepted beat (rd_valid / wr_ready drop), giving 1 beat per 2 cycles.
module cache_mem_responder #(
  parameter int mem_depth  = 32,
  parameter int data_width = 32,
  parameter int addr_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [addr_width-1:0] rd_addr,
  input  logic [15:0]           rd_len,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  input  logic                  rd_ready,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [15:0]           wr_len,
  output logic                  wr_gnt,
  input  logic                  wr_valid,
  input  logic [data_width-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic                  wr_done
);

  localparam int idx_w = $clog2(mem_depth);

`ifdef MEM_RSP_STALL_EN
  localparam bit stall_en = 1'b1;
`else
  localparam bit stall_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [idx_w-1:0] ptr_q, ptr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             stall_q, stall_d;

  logic [data_width-1:0] mem [mem_depth];

  logic rd_beat;
  logic wr_beat;

  // Address bits above the array index select nothing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[addr_width-1:idx_w],
                              wr_addr[addr_width-1:idx_w]};

  function automatic logic [idx_w-1:0] ptr_inc(
    input logic [idx_w-1:0] p
  );
    if (p == idx_w'(mem_depth - 1)) return '0;
    return p + idx_w'(1);
  endfunction

  assign rd_beat = rd_valid && rd_ready;
  assign wr_beat = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      stall_q <= stall_d;
    end
  end

  // Backing array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_beat) mem[ptr_q] <= wr_data;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    stall_d  = 1'b0;
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    rd_valid = 1'b0;
    wr_ready = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write-back wins so the victim leaves before the fill lands.
        if (!rst && wr_req) begin
          wr_gnt  = 1'b1;
          ptr_d   = wr_addr[idx_w-1:0];
          cnt_d   = wr_len;
          is_wr_d = 1'b1;
          state_d = (wr_len == 16'd0) ? DONE : WR_BURST;
        end else if (!rst && rd_req) begin
          rd_gnt  = 1'b1;
          ptr_d   = rd_addr[idx_w-1:0];
          cnt_d   = rd_len;
          is_wr_d = 1'b0;
          state_d = (rd_len == 16'd0) ? DONE : RD_BURST;
        end
      end
      RD_BURST: begin
        rd_valid = !stall_q;
        if (rd_beat) begin
          ptr_d   = ptr_inc(ptr_q);
          cnt_d   = cnt_q - 16'd1;
          stall_d = stall_en;
          if (cnt_q == 16'd1) state_d = DONE;
        end
      end
      WR_BURST: begin
        wr_ready = !stall_q;
        if (wr_beat) begin
          ptr_d   = ptr_inc(ptr_q);
          cnt_d   = cnt_q - 16'd1;
          stall_d = stall_en;
          if (cnt_q == 16'd1 || wr_last) state_d = DONE;
        end
      end
      DONE: begin
        rd_done = !is_wr_q;
        wr_done = is_wr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (rd_valid) rd_data = mem[ptr_q];
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder with a word-array reference model
// and a per-cycle read-data / output-exclusivity checker.
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [15:0] rd_len;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        rd_done;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [15:0] wr_len;
  logic        wr_gnt;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        wr_done;

  cache_mem_responder dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_gnt(wr_gnt), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

`ifdef MEM_RSP_STALL_EN
  localparam int beat_gap = 2;
`else
  localparam int beat_gap = 1;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wr_done_cyc;
  int rd_gnt_cyc;

  logic [31:0] mem_m [32];
  logic [31:0] exp_q [$];
  logic [31:0] got   [16];

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle checker: exclusivity and read data against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk($countones({rd_gnt, wr_gnt, rd_valid, wr_ready,
                      rd_done, wr_done}) <= 1, "one_active",
          {26'd0, rd_gnt, wr_gnt, rd_valid, wr_ready, rd_done, wr_done},
          32'd0);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "rd_unexpected_beat", rd_data, 32'd0);
        end else begin
          chk(rd_data == exp_q[0], "rd_data", rd_data, exp_q[0]);
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [31:0] base, input int last_idx,
                          input bit with_rd, input logic [31:0] raddr,
                          input int rlen);
    int  nb;
    int  w;
    bit  trunc;
    trunc = (last_idx >= 0 && last_idx < len - 1);
    nb = trunc ? last_idx + 1 : len;
    @(posedge clk); #1;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_len  = 16'(len);
    if (with_rd) begin
      rd_req  = 1'b1;
      rd_addr = raddr;
      rd_len  = 16'(rlen);
    end
    w = 0;
    forever begin
      @(negedge clk);
      if (wr_gnt || w >= 50) break;
      w++;
    end
    chk(wr_gnt, "wr_gnt", {31'd0, wr_gnt}, 32'd1);
    if (!wr_gnt) return;
    @(posedge clk); #1;
    wr_req = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      wr_last  = (i == last_idx);
      w = 0;
      forever begin
        @(negedge clk);
        if (wr_ready || w >= 20) break;
        w++;
      end
      chk(wr_ready, "wr_ready_beat", {31'd0, wr_ready}, 32'd1);
      mem_m[(addr + 32'(i)) & 32'd31] = base + 32'(i);
      @(posedge clk); #1;
    end
    wr_last = 1'b0;
    if (trunc) begin
      wr_valid = 1'b1;
      wr_data  = 32'hDEAD_BEEF;
    end else begin
      wr_valid = 1'b0;
    end
    @(negedge clk);
    chk(wr_done, "wr_done", {31'd0, wr_done}, 32'd1);
    chk(!wr_ready, "wr_ready_in_done", {31'd0, wr_ready}, 32'd0);
    wr_done_cyc = cyc;
    if (trunc) begin
      repeat (2) begin
        @(negedge clk);
        chk(!wr_ready, "wr_ready_after_last", {31'd0, wr_ready}, 32'd0);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [3:0] pat, input int abort_at);
    int beats;
    int k;
    int w;
    int first_cyc;
    int last_cyc;
    beats = 0;
    k = 0;
    first_cyc = 0;
    last_cyc = 0;
    for (int i = 0; i < len; i++)
      exp_q.push_back(mem_m[(addr + 32'(i)) & 32'd31]);
    @(posedge clk); #1;
    rd_req  = 1'b1;
    rd_addr = addr;
    rd_len  = 16'(len);
    w = 0;
    forever begin
      @(negedge clk);
      if (rd_gnt || w >= 50) break;
      w++;
    end
    chk(rd_gnt, "rd_gnt", {31'd0, rd_gnt}, 32'd1);
    if (!rd_gnt) begin
      exp_q.delete();
      return;
    end
    rd_gnt_cyc = cyc;
    @(posedge clk); #1;
    rd_req = 1'b0;
    while (beats < len && k < 200) begin
      rd_ready = pat[k % 4];
      @(negedge clk);
      if (k == 0)
        chk(rd_valid, "rd_first_latency", {31'd0, rd_valid}, 32'd1);
      if (rd_valid && rd_ready) begin
        if (beats < 16) got[beats] = rd_data;
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      k++;
      @(posedge clk); #1;
      if (abort_at >= 0 && beats == abort_at) begin
        rst      = 1'b1;
        rd_ready = 1'b0;
        exp_q.delete();
        #1;
        chk({rd_gnt, rd_valid, rd_done, wr_gnt, wr_ready, wr_done} == 6'd0
            && rd_data == 32'd0, "outputs_on_reset", rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk(!rd_done, "no_rd_done_after_abort", {31'd0, rd_done}, 32'd0);
        end
        return;
      end
    end
    rd_ready = 1'b0;
    chk(beats == len, "rd_beat_count", 32'(beats), 32'(len));
    @(negedge clk);
    chk(rd_done, "rd_done", {31'd0, rd_done}, 32'd1);
    if (pat == 4'hF && len > 1)
      chk(last_cyc - first_cyc == (len - 1) * beat_gap, "rd_beat_spacing",
          32'(last_cyc - first_cyc), 32'((len - 1) * beat_gap));
    chk(exp_q.size() == 0, "rd_exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({rd_gnt, rd_valid, rd_done, wr_gnt, wr_ready, wr_done} == 6'd0,
        "reset_outputs",
        {26'd0, rd_gnt, rd_valid, rd_done, wr_gnt, wr_ready, wr_done},
        32'd0);
    chk(rd_data == 32'd0, "reset_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back.
    do_write(32'd4, 4, 32'h0000_00A0, -1, 1'b0, 32'd0, 0);
    do_read(32'd4, 4, 4'hF, -1);
    chk(got[0] == 32'h0000_00A0, "lit_a0", got[0], 32'h0000_00A0);
    chk(got[3] == 32'h0000_00A3, "lit_a3", got[3], 32'h0000_00A3);

    // Simultaneous requests: write first, read right after wr_done.
    do_write(32'd16, 3, 32'h0000_00E0, -1, 1'b1, 32'd16, 3);
    do_read(32'd16, 3, 4'hF, -1);
    chk(rd_gnt_cyc == wr_done_cyc + 1, "rd_gnt_after_wr_done",
        32'(rd_gnt_cyc - wr_done_cyc), 32'd1);
    chk(got[2] == 32'h0000_00E2, "lit_e2", got[2], 32'h0000_00E2);

    // Wrap at the top of the array; upper address bits ignored on read.
    do_write(32'd30, 4, 32'h0000_00D0, -1, 1'b0, 32'd0, 0);
    do_read(32'hFFFF_FFFE, 4, 4'hF, -1);
    chk(got[2] == 32'h0000_00D2, "lit_wrap_idx0", got[2], 32'h0000_00D2);
    do_read(32'd0, 2, 4'hF, -1);
    chk(got[1] == 32'h0000_00D3, "lit_wrap_idx1", got[1], 32'h0000_00D3);

    // Backpressure pattern 1,0,0,1.
    do_read(32'd4, 4, 4'b1001, -1);
    chk(got[1] == 32'h0000_00A1, "lit_bp_a1", got[1], 32'h0000_00A1);

    // Early wr_last on beat 2 of 8.
    do_write(32'd8, 8, 32'h0000_00B0, -1, 1'b0, 32'd0, 0);
    do_write(32'd8, 8, 32'h0000_00C0, 1, 1'b0, 32'd0, 0);
    do_read(32'd8, 8, 4'hF, -1);
    chk(got[1] == 32'h0000_00C1, "lit_trunc_c1", got[1], 32'h0000_00C1);
    chk(got[2] == 32'h0000_00B2, "lit_trunc_b2", got[2], 32'h0000_00B2);

    // Zero-length bursts.
    do_write(32'd0, 0, 32'h0, -1, 1'b0, 32'd0, 0);
    do_read(32'd0, 0, 4'hF, -1);

    // Reset in the middle of a read, then a fresh read.
    do_read(32'd8, 8, 4'hF, 2);
    do_read(32'd4, 4, 4'hF, -1);
    chk(got[0] == 32'h0000_00A0, "lit_after_reset", got[0], 32'h0000_00A0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
